// File: rtl/backprop_epoch_sched_if.sv
// Bundle of all scheduler-facing signals: host control, key ROM, core handshake and weights RAM port.
// slave is the scheduler's view; master is the environment's view.
interface backprop_epoch_sched_if #(
    parameter int KEY_W    = 3071,
    parameter int KEY_WORD = 32,
    parameter int CNT_W    = 16,
    parameter int KADDR_W  = 7
);
    logic                start;
    logic [CNT_W-1:0]    epochs;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    epoch_cnt;

    logic [KADDR_W-1:0]  key_rom_addr;
    logic                key_rom_ce;
    logic [KEY_WORD-1:0] key_rom_q;
    logic [KEY_W-1:0]    working_key;

    logic                core_start;
    logic                core_ready;
    logic                core_done;
    logic                core_idle;

    logic [7:0]          host_we_addr;
    logic                host_ce;
    logic                host_we;
    logic [63:0]         host_d;
    logic [7:0]          core_w_addr;
    logic                core_w_ce;
    logic                core_w_we;
    logic [63:0]         core_w_d;
    logic [7:0]          mem_addr;
    logic                mem_ce;
    logic                mem_we;
    logic [63:0]         mem_d;
    logic                host_grant;

    modport slave (
        input  start, epochs, key_rom_q, core_ready, core_done, core_idle,
               host_we_addr, host_ce, host_we, host_d,
               core_w_addr, core_w_ce, core_w_we, core_w_d,
        output busy, done, epoch_cnt, key_rom_addr, key_rom_ce, working_key,
               core_start, mem_addr, mem_ce, mem_we, mem_d, host_grant
    );

    modport master (
        output start, epochs, key_rom_q, core_ready, core_done, core_idle,
               host_we_addr, host_ce, host_we, host_d,
               core_w_addr, core_w_ce, core_w_we, core_w_d,
        input  busy, done, epoch_cnt, key_rom_addr, key_rom_ce, working_key,
               core_start, mem_addr, mem_ce, mem_we, mem_d, host_grant
    );
endinterface

// File: rtl/backprop_epoch_sched.sv
// Epoch sequencer for the locked backprop core: loads the working key from ROM, runs the core N times, owns the weights port.
// Latency: NWORDS+1 key-load cycles, then one ap_ctrl_hs run per epoch; optional KEY_CLEAR_ON_DONE_EN zeroes the key on done.
// Backpressure: core_start is held until core_ready; host start is ignored while busy.
module backprop_epoch_sched #(
    parameter int KEY_W    = 3071,
    parameter int KEY_WORD = 32,
    parameter int CNT_W    = 16,
    parameter int KADDR_W  = 7
) (
    input  logic ap_clk,
    input  logic ap_rst,
    backprop_epoch_sched_if.slave bus
);
    localparam int NWORDS = (KEY_W + KEY_WORD - 1) / KEY_WORD;
    localparam int WCNT_W = KADDR_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_RUN, S_WAIT, S_FIN} state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   word_q, word_d;
    logic                wr_vld_q;
    logic [KADDR_W-1:0]  wr_idx_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    epochs_q, epochs_d;
    logic [CNT_W-1:0]    cnt_inc;
    logic [KEY_W-1:0]    key_q, key_d, key_ld;
    logic                rom_ce;
    logic [KADDR_W-1:0]  rom_addr;
    logic                epoch_hit;
    logic                unused_core_idle;

    assign unused_core_idle = bus.core_idle;
    assign cnt_inc          = cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        epochs_d  = epochs_q;
        rom_ce    = 1'b0;
        rom_addr  = '0;
        epoch_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cnt_d = '0;
                    if (bus.epochs == '0) begin
                        state_d = S_FIN;
                    end else begin
                        epochs_d = bus.epochs;
                        word_d   = '0;
                        state_d  = S_KEY;
                    end
                end
            end
            S_KEY: begin
                // Final KEY cycle issues nothing; it only lets the last word land.
                if (word_q < WCNT_W'(NWORDS)) begin
                    rom_ce   = 1'b1;
                    rom_addr = word_q[KADDR_W-1:0];
                    word_d   = word_q + WCNT_W'(1);
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.core_ready) begin
                    if (bus.core_done) begin
                        epoch_hit = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.core_done) begin
                    epoch_hit = 1'b1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (epoch_hit) begin
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == epochs_q) ? S_FIN : S_RUN;
        end
    end

    // The top word is truncated to the bits that exist in the working key.
    for (genvar w = 0; w < NWORDS; w++) begin : g_word
        localparam int LO = w * KEY_WORD;
        localparam int WW = ((KEY_W - LO) < KEY_WORD) ? (KEY_W - LO) : KEY_WORD;
        assign key_ld[LO +: WW] = (wr_vld_q && (wr_idx_q == KADDR_W'(w)))
                                  ? bus.key_rom_q[WW-1:0] : key_q[LO +: WW];
    end

    always_comb begin
        key_d = key_ld;
`ifdef KEY_CLEAR_ON_DONE_EN
        if (state_q == S_FIN) begin
            key_d = '0;
        end
`endif
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= S_IDLE;
            word_q   <= '0;
            wr_vld_q <= 1'b0;
            wr_idx_q <= '0;
            cnt_q    <= '0;
            epochs_q <= '0;
            key_q    <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            wr_vld_q <= rom_ce;
            wr_idx_q <= rom_addr;
            cnt_q    <= cnt_d;
            epochs_q <= epochs_d;
            key_q    <= key_d;
        end
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_FIN);
    assign bus.epoch_cnt    = cnt_q;
    assign bus.key_rom_ce   = rom_ce;
    assign bus.key_rom_addr = rom_addr;
    assign bus.working_key  = key_q;
    assign bus.core_start   = (state_q == S_RUN);
    assign bus.host_grant   = (state_q == S_IDLE);

    // Only the granted side's enables ever reach the RAM.
    assign bus.mem_addr = bus.host_grant ? bus.host_we_addr : bus.core_w_addr;
    assign bus.mem_ce   = bus.host_grant ? bus.host_ce      : bus.core_w_ce;
    assign bus.mem_we   = bus.host_grant ? bus.host_we      : bus.core_w_we;
    assign bus.mem_d    = bus.host_grant ? bus.host_d       : bus.core_w_d;
endmodule

// File: tb/tb_backprop_epoch_sched.sv
// Bench for backprop_epoch_sched: job-level reference model, ROM and core responders, directed scenarios.
module tb_backprop_epoch_sched;
    localparam int KEY_W = 3071;
    localparam int NW    = 96;
    localparam int PH_IDLE = 0, PH_LOAD = 1, PH_REQ = 2, PH_WAIT = 3, PH_FIN = 4;

    logic clk = 1'b0;
    logic ap_rst;
    always #5 clk = ~clk;

    backprop_epoch_sched_if bus ();
    backprop_epoch_sched dut (.ap_clk(clk), .ap_rst(ap_rst), .bus(bus));

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;
    int cyc = 0;
    int rdy_lat = 2, done_lat = 10;
    int ce_cnt, addr_err, cs_rise, hs_cnt, done_cnt, first_cs_cyc;
    logic cs_prev = 1'b0;

    function automatic logic [31:0] rom_word(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    function automatic logic [KEY_W-1:0] full_key();
        logic [NW*32-1:0] p;
        for (int i = 0; i < NW; i++) p[i*32 +: 32] = rom_word(i);
        return p[KEY_W-1:0];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_key(input string nm, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got lo=%h hi=%h expected lo=%h hi=%h (t=%0t)", nm,
                     act[31:0], act[KEY_W-1:KEY_W-31], exp[31:0], exp[KEY_W-1:KEY_W-31], $time);
        end
    endtask

    // Job-level reference model, advanced on each clock edge from the bench-driven inputs only.
    int m_phase = PH_IDLE, m_t = 0, m_cnt = 0, m_target = 0;
    logic [NW*32-1:0] m_keyp = '0;

    task automatic m_count();
        m_cnt++;
        m_phase = (m_cnt == m_target) ? PH_FIN : PH_REQ;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (ap_rst) begin
            m_phase = PH_IDLE; m_t = 0; m_cnt = 0; m_target = 0; m_keyp = '0;
        end else begin
            case (m_phase)
                PH_IDLE: if (bus.start) begin
                    m_cnt = 0;
                    if (bus.epochs == 0) m_phase = PH_FIN;
                    else begin m_target = int'(bus.epochs); m_t = 0; m_phase = PH_LOAD; end
                end
                PH_LOAD: begin
                    if (m_t >= 1) m_keyp[(m_t-1)*32 +: 32] = rom_word(m_t - 1);
                    if (m_t == NW) m_phase = PH_REQ; else m_t++;
                end
                PH_REQ: if (bus.core_ready) begin
                    if (bus.core_done) m_count(); else m_phase = PH_WAIT;
                end
                PH_WAIT: if (bus.core_done) m_count();
                PH_FIN: begin
                    m_phase = PH_IDLE;
`ifdef KEY_CLEAR_ON_DONE_EN
                    m_keyp = '0;
`endif
                end
                default: m_phase = PH_IDLE;
            endcase
        end
    end

    // Per-cycle comparison against the model, plus event counters.
    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit idle = (m_phase == PH_IDLE);
            automatic bit ce = (m_phase == PH_LOAD) && (m_t < NW);
            chk("busy", bus.busy, (m_phase != PH_IDLE));
            chk("done", bus.done, (m_phase == PH_FIN));
            chk("core_start", bus.core_start, (m_phase == PH_REQ));
            chk("key_rom_ce", bus.key_rom_ce, ce);
            chk("key_rom_addr", bus.key_rom_addr, ce ? m_t : 0);
            chk("epoch_cnt", bus.epoch_cnt, m_cnt);
            chk("host_grant", bus.host_grant, idle);
            chk("mem_addr", bus.mem_addr, idle ? bus.host_we_addr : bus.core_w_addr);
            chk("mem_ce", bus.mem_ce, idle ? bus.host_ce : bus.core_w_ce);
            chk("mem_we", bus.mem_we, idle ? bus.host_we : bus.core_w_we);
            chk("mem_d", bus.mem_d, idle ? bus.host_d : bus.core_w_d);
            chk_key("working_key", bus.working_key, m_keyp[KEY_W-1:0]);
        end
        if (bus.key_rom_ce) begin
            if (int'(bus.key_rom_addr) != ce_cnt) addr_err++;
            ce_cnt++;
        end
        if (bus.core_start && !cs_prev) begin
            cs_rise++;
            if (first_cs_cyc < 0) first_cs_cyc = cyc;
        end
        if (bus.core_start && bus.core_ready) hs_cnt++;
        if (bus.done) done_cnt++;
        cs_prev = bus.core_start;
    end

    // Synchronous key ROM: data one cycle after an enabled address.
    initial begin
        logic pend_ce;
        logic [6:0] pend_addr;
        bus.key_rom_q = '0;
        forever begin
            @(negedge clk);
            pend_ce = bus.key_rom_ce;
            pend_addr = bus.key_rom_addr;
            @(posedge clk);
            #1;
            if (pend_ce) bus.key_rom_q = rom_word(int'(pend_addr));
        end
    end

    // Core responder: ready rdy_lat cycles after start, done done_lat cycles after ready.
    initial begin
        int cs_age = 0, done_timer = 0;
        bus.core_ready = 1'b0; bus.core_done = 1'b0; bus.core_idle = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ap_rst) begin
                cs_age = 0; done_timer = 0;
                bus.core_ready = 1'b0; bus.core_done = 1'b0;
            end else begin
                if (!bus.core_start) cs_age = 0;
                else if (bus.core_ready) cs_age = 1;
                else cs_age++;
                bus.core_ready = bus.core_start && (cs_age == rdy_lat + 1);
                bus.core_done = 1'b0;
                if (done_timer > 0) begin
                    done_timer--;
                    if (done_timer == 0) bus.core_done = 1'b1;
                end
                if (bus.core_ready) begin
                    if (done_lat == 0) bus.core_done = 1'b1;
                    else done_timer = done_lat;
                end
            end
            bus.core_idle = !bus.core_start && (done_timer == 0);
        end
    end

    task automatic clear_counts();
        ce_cnt = 0; addr_err = 0; cs_rise = 0; hs_cnt = 0; done_cnt = 0; first_cs_cyc = -1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int n);
        bus.epochs = 16'(n);
        bus.start = 1'b1;
        next_cycle();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (bus.done) break;
        end
        chk(nm, bus.done, 1'b1);
        next_cycle();
    endtask

    initial begin
        int s_cyc;
        ap_rst = 1'b1;
        bus.start = 1'b0; bus.epochs = '0;
        bus.host_we_addr = 8'h00; bus.host_ce = 1'b0; bus.host_we = 1'b0; bus.host_d = '0;
        bus.core_w_addr = 8'h00; bus.core_w_ce = 1'b0; bus.core_w_we = 1'b0; bus.core_w_d = '0;
        clear_counts();
        next_cycle();
        next_cycle();
        ap_rst = 1'b0;
        chk_en = 1'b1;

        // Reset state and host ownership while idle
        bus.host_we_addr = 8'h12; bus.host_ce = 1'b1; bus.host_we = 1'b1; bus.host_d = 64'h1111_2222_3333_4444;
        bus.core_w_addr = 8'h34; bus.core_w_ce = 1'b1; bus.core_w_we = 1'b0; bus.core_w_d = 64'hDEAD_BEEF_0000_0001;
        @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_grant", bus.host_grant, 1'b1);
        chk("rst_epoch_cnt", bus.epoch_cnt, 0);
        chk_key("rst_key", bus.working_key, '0);
        chk("idle_mem_addr", bus.mem_addr, 64'h12);
        chk("idle_mem_we", bus.mem_we, 1'b1);
        next_cycle();

        // Single-epoch job: full key load
        clear_counts();
        s_cyc = cyc;
        pulse_start(1);
        wait_done("done_seen_e1", 400);
        chk("e1_rom_reads", ce_cnt, NW);
        chk("e1_addr_order", addr_err, 0);
        chk("e1_start_delay", first_cs_cyc - s_cyc, NW + 2);
        chk("e1_key_lo", bus.working_key[31:0], 64'hA500_0000);
        chk("e1_key_hi", bus.working_key[3070:3040], 64'h2500_005F);
        chk("e1_cs_rise", cs_rise, 1);
        chk("e1_epoch_cnt", bus.epoch_cnt, 1);

        // Three epochs, core owns the port, a stray start during the run
        clear_counts();
        pulse_start(3);
        for (int i = 0; i < 300 && cs_rise == 0; i++) next_cycle();
        for (int i = 0; i < 4; i++) next_cycle();
        bus.epochs = 16'd1; bus.start = 1'b1;
        @(negedge clk);
        chk("own_mem_we0", bus.mem_we, 1'b0);
        chk("own_mem_addr", bus.mem_addr, 64'h34);
        next_cycle();
        bus.start = 1'b0;
        bus.core_w_we = 1'b1;
        @(negedge clk);
        chk("own_mem_we1", bus.mem_we, 1'b1);
        next_cycle();
        bus.core_w_we = 1'b0;
        wait_done("done_seen_e3", 400);
        @(negedge clk);
        chk("e3_cs_rise", cs_rise, 3);
        chk("e3_epoch_cnt", bus.epoch_cnt, 3);
        chk("e3_done_cnt", done_cnt, 1);
        chk("e3_rom_reads", ce_cnt, NW);
`ifdef KEY_CLEAR_ON_DONE_EN
        chk_key("e3_key_cleared", bus.working_key, '0);
`else
        chk_key("e3_key_kept", bus.working_key, full_key());
`endif
        next_cycle();

        // Ready and done in the same cycle
        clear_counts();
        done_lat = 0;
        pulse_start(2);
        wait_done("done_seen_same", 400);
        chk("same_hs_cnt", hs_cnt, 2);
        chk("same_epoch_cnt", bus.epoch_cnt, 2);
        done_lat = 10;

        // Zero epochs: immediate done
        clear_counts();
        bus.epochs = 16'd0; bus.start = 1'b1;
        next_cycle();
        bus.start = 1'b0;
        @(negedge clk);
        chk("z_done", bus.done, 1'b1);
        chk("z_busy", bus.busy, 1'b1);
        next_cycle();
        @(negedge clk);
        chk("z_busy_drop", bus.busy, 1'b0);
        chk("z_rom_reads", ce_cnt, 0);
        chk("z_cs_rise", cs_rise, 0);
        next_cycle();

        // Reset while waiting on the core
        clear_counts();
        pulse_start(5);
        for (int i = 0; i < 300 && cs_rise == 0; i++) next_cycle();
        for (int i = 0; i < 20 && bus.core_start; i++) next_cycle();
        next_cycle();
        ap_rst = 1'b1;
        next_cycle();
        ap_rst = 1'b0;
        @(negedge clk);
        chk("ar_busy", bus.busy, 1'b0);
        chk("ar_core_start", bus.core_start, 1'b0);
        chk("ar_epoch_cnt", bus.epoch_cnt, 0);
        chk("ar_grant", bus.host_grant, 1'b1);
        chk_key("ar_key", bus.working_key, '0);
        next_cycle();
        next_cycle();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/backprop_epoch_sched.md
Name: backprop_epoch_sched

Overview:
- Sequencer in front of the locked backprop core.
- On a host start it streams the core's working key out of a synchronous key ROM into a shadow register. It then runs the core for a programmed number of epochs using the core's ap_start/ap_ready/ap_done handshake.
- Owns the single weights RAM port: the host sees it while the scheduler is idle, the core sees it while an epoch run is in progress.

Parameters:
- KEY_W, 3071, working key width driven to the core.
- KEY_WORD, 32, key ROM data width; NWORDS = ceil(KEY_W/KEY_WORD) (96 at defaults).
- CNT_W, 16, epoch counter width.
- KADDR_W, 7, key ROM address width; must satisfy 2^KADDR_W >= NWORDS.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst  in  1  synchronous active-high reset.
- start  in  1  host run request, single-cycle sample.
- epochs  in  CNT_W  number of core runs, captured at accepted start.
- busy  out  1  high from accepted start until the done pulse, inclusive.
- done  out  1  one-cycle completion pulse.
- epoch_cnt  out  CNT_W  completed core runs in the current job.
- key_rom_addr  out  KADDR_W  key ROM address.
- key_rom_ce  out  1  key ROM read enable.
- key_rom_q  in  KEY_WORD  key ROM data, valid 1 cycle after ce.
- working_key  out  KEY_W  key to core.
- core_start / core_ready / core_done / core_idle  out/in/in/in  1 each  ap_ctrl_hs to core.
- host_we_addr  in  8  host weights address.
- host_ce, host_we  in  1 each  host weights enables.
- host_d  in  64  host weights write data.
- core_w_addr  in  8  core weights address.
- core_w_ce, core_w_we  in  1 each  core weights enables.
- core_w_d  in  64  core weights write data.
- mem_addr  out  8  to weights RAM.
- mem_ce, mem_we  out  1 each  to weights RAM.
- mem_d  out  64  to weights RAM.
- host_grant  out  1  high when the host owns the weights port.

Behaviour:
- Reset (ap_clk edge with ap_rst=1): state IDLE; working_key=0; epoch_cnt=0; busy=0; done=0; core_start=0; key_rom_ce=0; key_rom_addr=0; host_grant=1. Reset mid-run aborts immediately; the core is not drained.
- IDLE: start=1 and epochs!=0 → capture epochs, epoch_cnt←0, busy←1, go to KEY. start=1 and epochs==0 → done pulses next cycle with busy=1 that cycle only; no ROM read, no core start. start while busy is ignored.
- KEY:
  - Issues addresses 0..NWORDS-1 on consecutive cycles with key_rom_ce=1.
  - Word i, arriving the cycle after its address, is written to working_key[i*KEY_WORD +: KEY_WORD]; bits above KEY_W-1 are discarded.
  - Load time is NWORDS+1 cycles, then go to RUN.
- RUN:
  - Assert core_start and hold it until core_ready=1 is sampled, then drop it the next cycle.
  - Go to WAIT. If core_done=1 in the same cycle as core_ready, count the epoch without waiting.
- WAIT: on core_done=1, epoch_cnt+1. If epoch_cnt+1 == captured epochs → go to FIN; else go to RUN. The key is not reloaded between epochs.
- FIN: done=1 for one cycle, busy drops the following cycle, return to IDLE.
- Weights mux (combinational):
  - host_grant = (state==IDLE).
  - When granted, mem_* = host signals; otherwise mem_* = core signals.
  - The non-granted side's ce/we never reach the RAM. mem_q is shared externally.
- core_idle is informational only; no transition depends on it.
- epoch_cnt holds its final value after done until the next accepted start.

Optional Feature:
- Macro KEY_CLEAR_ON_DONE_EN.
- Defined: working_key is cleared to 0 in the FIN cycle, so the core is locked whenever the scheduler is idle.
- Undefined: working_key retains the loaded key until reset or the next KEY load.

Test Plan:
- Reset, then idle: all outputs hold their reset values; host_addr=0x12, host_ce=1, host_we=1 → mem_addr=0x12, mem_we=1.
- Key load: ROM word i = 0xA5000000|i, start with epochs=1:
  - Addresses 0..95 are issued.
  - working_key[31:0]=0xA5000000; bits [3070:3040] = low 31 bits of word 95.
  - Then core_start rises.
- Three epochs: core_ready asserted 2 cycles after core_start, core_done 10 cycles later:
  - Exactly 3 core_start assertions.
  - epoch_cnt reaches 3; done pulses once.
  - No ROM access after the first load.
- epochs=0: done pulses 1 cycle after start; key_rom_ce and core_start stay 0.
- Ownership: host_we=1 held during an epoch → mem_we follows core_w_we only. Start asserted while busy → ignored.
- ap_rst asserted during WAIT → next cycle matches the reset state. With KEY_CLEAR_ON_DONE_EN: working_key=0 after done.
